// File: rtl/sid_bus_master.sv
// sid_bus_master: turns valid/ready register accesses into full PHI2 bus cycles towards a SID chip.
// Ports: clk/rst_n (async active-low); req_valid/req_ready/req_addr/req_write/req_wdata request side;
// resp_valid (completion pulse) / resp_rdata (read data); bus_phi2, bus_a, bus_r_wn, bus_csn,
// bus_d_o/bus_d_oe (pad drive) and bus_d_i (asynchronous pad input) on the SID side.
module sid_bus_master #(
  parameter int AW       = 5,
  parameter int DIV_HALF = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic          req_write,
  input  logic [7:0]    req_wdata,
  output logic          resp_valid,
  output logic [7:0]    resp_rdata,
  output logic          bus_phi2,
  output logic [AW-1:0] bus_a,
  output logic          bus_r_wn,
  output logic          bus_csn,
  output logic [7:0]    bus_d_o,
  output logic          bus_d_oe,
  input  logic [7:0]    bus_d_i
);
  localparam int CW = $clog2(DIV_HALF);
  localparam logic [CW-1:0] CMAX = CW'(DIV_HALF - 1);
  localparam logic [CW-1:0] HMAX = CW'(HOLD_CYC - 1);
  typedef enum logic [2:0] {IDLE, WAIT, LOW, HIGH, HOLD} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d, hcnt_q;
  logic          phi2_q, phi2_d, wrap, rise_evt, fall_evt;
  logic [7:0]    sync1_q, d_sync_q;
  logic [AW-1:0] addr_q, bus_a_q;
  logic          write_q, req_ready_q, resp_valid_q, bus_r_wn_q, bus_csn_q, bus_d_oe_q;
  logic [7:0]    wdata_q, resp_rdata_q, bus_d_o_q;
  // PHI2 runs free of the request side; every bus cycle aligns to its edges.
  always_comb begin
    wrap     = cnt_q == CMAX;
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    phi2_d   = wrap ? ~phi2_q : phi2_q;
    rise_evt = wrap & ~phi2_q;
    fall_evt = wrap & phi2_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q    <= '0;
      phi2_q   <= 1'b0;
      sync1_q  <= '0;
      d_sync_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      phi2_q   <= phi2_d;
      sync1_q  <= bus_d_i;
      d_sync_q <= sync1_q;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      hcnt_q       <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      bus_a_q      <= '0;
      bus_r_wn_q   <= 1'b1;
      bus_csn_q    <= 1'b1;
      bus_d_o_q    <= '0;
      bus_d_oe_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q      <= req_addr;
          write_q     <= req_write;
          wdata_q     <= req_wdata;
          req_ready_q <= 1'b0;
          state_q     <= WAIT;
        end
        // A fall on the accept edge itself is not seen here, so the cycle starts a full period later.
        WAIT: if (fall_evt) begin
          bus_a_q    <= addr_q;
          bus_r_wn_q <= ~write_q;
          bus_csn_q  <= 1'b0;
          state_q    <= LOW;
        end
        LOW: if (rise_evt) begin
          bus_d_oe_q <= write_q;
          bus_d_o_q  <= write_q ? wdata_q : bus_d_o_q;
          state_q    <= HIGH;
        end
        HIGH: if (fall_evt) begin
          resp_rdata_q <= write_q ? resp_rdata_q : d_sync_q;
          hcnt_q       <= '0;
          state_q      <= HOLD;
        end
        // Address/data hold time after PHI2 falls; bus_a is left parked on release.
        HOLD: if (hcnt_q == HMAX) begin
          bus_csn_q    <= 1'b1;
          bus_r_wn_q   <= 1'b1;
          bus_d_oe_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end else begin
          hcnt_q <= hcnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign bus_phi2   = phi2_q;
  assign bus_a      = bus_a_q;
  assign bus_r_wn   = bus_r_wn_q;
  assign bus_csn    = bus_csn_q;
  assign bus_d_o    = bus_d_o_q;
  assign bus_d_oe   = bus_d_oe_q;
endmodule

// File: tb/tb_sid_bus_master.sv
// tb_sid_bus_master: random and directed accesses against a timing model of the SID bus cycle.
module tb_sid_bus_master;
  localparam int AW = 5, DH = 4, HC = 1, PER = 2 * DH;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [7:0]    req_wdata = '0, bus_d_i = '0;
  logic          req_ready, resp_valid, bus_phi2, bus_r_wn, bus_csn, bus_d_oe;
  logic [7:0]    resp_rdata, bus_d_o;
  logic [AW-1:0] bus_a;
  int            total = 0, bad = 0, n = 0;
  logic [7:0]    sid_mem [32];
  logic [7:0]    exp_mem [32];
  sid_bus_master #(.AW(AW), .DIV_HALF(DH), .HOLD_CYC(HC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .bus_phi2(bus_phi2), .bus_a(bus_a), .bus_r_wn(bus_r_wn), .bus_csn(bus_csn),
    .bus_d_o(bus_d_o), .bus_d_oe(bus_d_oe), .bus_d_i(bus_d_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s n=%0d actual=%0h required=%0h", nm, n, act, exp);
    end
  endtask
  // Model: n counts clk edges since reset release. PHI2 is high for n/DH odd; falls land on
  // multiples of PER. An access accepted at edge n owns the bus from the next fall F > n
  // until F+PER+HC, drives write data from F+DH, and completes with a pulse at F+PER+HC.
  logic          busy = 1'b0, t_w = 1'b0, resp = 1'b0, in_cyc, rv, rw;
  int            f = 0;
  logic [AW-1:0] t_a = '0, last_a = '0, ra;
  logic [7:0]    t_d = '0, rdata_exp = '0, rd;
  always begin
    @(posedge clk);
    rv = req_valid; ra = req_addr; rw = req_write; rd = req_wdata;
    if (!rst_n) begin
      n = 0; busy = 1'b0; resp = 1'b0; rdata_exp = '0; last_a = '0;
    end else begin
      n++;
      resp = 1'b0;
      if (!busy) begin
        if (rv) begin
          busy = 1'b1; f = (n / PER + 1) * PER; t_a = ra; t_w = rw; t_d = rd;
        end
      end else begin
        if (n == f + PER) begin
          if (t_w) exp_mem[t_a] = t_d;
          else rdata_exp = exp_mem[t_a];
        end
        if (n == f + PER + HC) begin
          busy = 1'b0; resp = 1'b1;
        end
      end
    end
    #1;
    in_cyc = busy && n >= f;
    if (in_cyc) last_a = t_a;
    chk("phi2", bus_phi2, (n / DH) % 2);
    chk("csn", bus_csn, !in_cyc);
    chk("r_wn", bus_r_wn, in_cyc ? !t_w : 1'b1);
    chk("a", bus_a, last_a);
    chk("oe", bus_d_oe, in_cyc && t_w && n >= f + DH);
    if (in_cyc && t_w && n >= f + DH) chk("d_o", bus_d_o, t_d);
    chk("ready", req_ready, !busy);
    chk("resp_valid", resp_valid, resp);
    chk("rdata", resp_rdata, rdata_exp);
    chk("oe_while_read", bus_d_oe & bus_r_wn, 0);
  end
  // SID stand-in: latches write data late in PHI2 high, drives read data while PHI2 is high.
  always @(negedge clk) begin
    if (rst_n && !bus_csn && !bus_r_wn && bus_d_oe && n % PER == PER - 1) sid_mem[bus_a] = bus_d_o;
    bus_d_i = (!bus_csn && bus_r_wn && bus_phi2) ? sid_mem[bus_a] : 8'($urandom);
  end
  task automatic wait_n(input int t);
    int g = 0;
    while (n < t && g < 1000) begin @(negedge clk); g++; end
  endtask
  task automatic wait_ready();
    int g = 0;
    while (!req_ready && g < 64) begin @(negedge clk); g++; end
    chk("ready_timeout", req_ready, 1);
  endtask
  task automatic issue(input logic [AW-1:0] a, input logic w, input logic [7:0] d, output int acc);
    wait_ready();
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d;
    @(negedge clk);
    acc = n;
    req_valid = 1'b0;
  endtask
  task automatic wait_resp(output logic [7:0] r);
    int g = 0;
    while (!resp_valid && g < 64) begin @(negedge clk); g++; end
    chk("resp_timeout", resp_valid, 1);
    r = resp_rdata;
  endtask
  initial begin
    int acc, last, pulses;
    logic [7:0] r;
    for (int i = 0; i < 32; i++) begin
      sid_mem[i] = 8'($urandom);
      exp_mem[i] = sid_mem[i];
    end
    sid_mem[5'h1B] = 8'hA5;
    exp_mem[5'h1B] = 8'hA5;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    while (n < 12) begin
      @(negedge clk);
      if (n == 2) begin chk("rst_ready", req_ready, 1); chk("rst_csn", bus_csn, 1); end
      if (n == 3) chk("phi2_n3", bus_phi2, 0);
      if (n == 4) chk("phi2_n4", bus_phi2, 1);
      if (n == 7) chk("phi2_n7", bus_phi2, 1);
      if (n == 8) chk("phi2_n8", bus_phi2, 0);
    end
    issue(5'h18, 1'b1, 8'h0F, acc);
    wait_n(16);
    chk("wr_a", bus_a, 5'h18); chk("wr_rwn", bus_r_wn, 0); chk("wr_csn", bus_csn, 0); chk("wr_oe_low", bus_d_oe, 0);
    wait_n(20);
    chk("wr_oe", bus_d_oe, 1); chk("wr_d", bus_d_o, 8'h0F);
    wait_n(24);
    chk("wr_hold_csn", bus_csn, 0); chk("wr_hold_oe", bus_d_oe, 1);
    wait_n(25);
    chk("wr_rel_csn", bus_csn, 1); chk("wr_rel_oe", bus_d_oe, 0); chk("wr_rel_rwn", bus_r_wn, 1); chk("wr_resp", resp_valid, 1);
    wait_n(26);
    chk("wr_resp_1clk", resp_valid, 0);
    issue(5'h1B, 1'b0, 8'h00, acc);
    wait_n(41);
    chk("rd_resp", resp_valid, 1); chk("rd_data", resp_rdata, 8'hA5);
    wait_n(47);
    issue(5'h05, 1'b1, 8'h3C, acc);
    wait_n(55);
    chk("fall_req_csn", bus_csn, 1); chk("fall_req_ready", req_ready, 0);
    wait_n(56);
    chk("fall_req_start", bus_csn, 0);
    wait_n(65);
    chk("fall_req_resp", resp_valid, 1);
    wait_n(66);
    chk("sid_wr", sid_mem[5], 8'h3C);
    req_valid = 1'b1; req_addr = 5'h18; req_write = 1'b0;
    last = -1; pulses = 0;
    repeat (70) begin
      @(negedge clk);
      if (resp_valid) begin
        if (last >= 0) chk("b2b_gap", n - last, 2 * PER);
        else chk("b2b_rd", resp_rdata, 8'h0F);
        last = n; pulses++;
      end
    end
    req_valid = 1'b0;
    chk("b2b_count", pulses, 4);
    wait_ready();
    issue(5'h02, 1'b1, 8'h77, acc);
    wait_n((acc / PER + 1) * PER + DH + 1);
    chk("abort_oe_before", bus_d_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_oe", bus_d_oe, 0); chk("abort_csn", bus_csn, 1); chk("abort_phi2", bus_phi2, 0);
    chk("abort_rwn", bus_r_wn, 1); chk("abort_resp", resp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_n(4);
    chk("restart_phi2", bus_phi2, 1); chk("restart_ready", req_ready, 1);
    issue(5'h18, 1'b0, 8'h00, acc);
    wait_resp(r);
    chk("restart_rd", r, 8'h0F);
    repeat (2500) begin
      @(negedge clk);
      req_valid = $urandom_range(0, 2) == 0;
      req_addr  = AW'($urandom);
      req_write = 1'($urandom);
      req_wdata = 8'($urandom);
    end
    req_valid = 1'b0;
    wait_ready();
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
